// File: rtl/dmem_line_responder.sv
// Line-granular data memory behind the L1 data cache: one 256-bit read or write
// at a time, acknowledged with a single-cycle pulse a fixed LATENCY after acceptance.
module dmem_line_responder #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [7:0]  LAST_COUNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [7:0]              count;
  logic [7:0]              next_count;
  logic                    accept;
  logic                    finish;

  logic [DEPTH_LOG2-1:0]   req_index;
  logic [255:0]            req_data;
  logic                    req_write;

  logic [DEPTH_LOG2-1:0]   addr_index;
  logic [DEPTH_LOG2-1:0]   commit_index;
  logic [255:0]            commit_data;
  logic                    commit_write;

  logic [255:0]            mem [DEPTH];

  logic                    unused_addr;

  assign addr_index  = addr_i[5 +: DEPTH_LOG2];
  assign unused_addr = ^{addr_i[4:0], addr_i[31:5+DEPTH_LOG2]};

  // With LATENCY=1 the commit happens on the accepting edge itself, so the
  // live inputs are used instead of the not-yet-latched request.
  assign commit_index = accept ? addr_index : req_index;
  assign commit_data  = accept ? data_i     : req_data;
  assign commit_write = accept ? write_i    : req_write;

  always_comb begin
    next_state = state;
    next_count = count;
    accept     = 1'b0;
    finish     = 1'b0;
    ack_o      = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          accept     = 1'b1;
          next_count = 8'd1;
          if (LATENCY == 1) begin
            next_state = ACK;
            finish     = 1'b1;
          end else begin
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        if (!enable_i) begin
          next_state = IDLE;
          next_count = 8'd0;
        end else if (count == LAST_COUNT) begin
          next_state = ACK;
          finish     = 1'b1;
        end else begin
          next_count = count + 8'd1;
        end
      end
      ACK: begin
        ack_o      = 1'b1;
        next_state = IDLE;
        next_count = 8'd0;
      end
      default: begin
        next_state = IDLE;
        next_count = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      count     <= 8'd0;
      req_index <= '0;
      req_data  <= '0;
      req_write <= 1'b0;
      data_o    <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
      if (accept) begin
        req_index <= addr_index;
        req_data  <= data_i;
        req_write <= write_i;
      end
      if (finish && !commit_write) begin
        data_o <= mem[commit_index];
      end
    end
  end

  // Array has no reset; gating on rst_i keeps a held-in-reset request from committing.
  always_ff @(posedge clk_i) begin
    if (finish && commit_write && rst_i) begin
      mem[commit_index] <= commit_data;
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: table of single transactions on a
// LATENCY=10 instance plus hand sequences for abort, reset, back-to-back and LATENCY=1.
module tb_dmem_line_responder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         write_i;
  logic         en0;
  logic         en1;
  logic         ack0;
  logic         ack1;
  logic [255:0] dout0;
  logic [255:0] dout1;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] LINE_P1 = {8{32'h11112222}};
  localparam logic [255:0] LINE_P0 = {8{32'h0F0F0F0F}};
  localparam logic [255:0] LINE_DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] LINE_X  = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] LINE_W  = {8{32'hCAFEF00D}};
  localparam logic [255:0] LINE_J  = {8{32'hBAADBAAD}};
  localparam logic [255:0] LINE_Z  = {8{32'h5A5A1234}};
  localparam logic [255:0] LINE_V  = {8{32'h76543210}};

  always #5 clk_i = ~clk_i;

  dmem_line_responder #(.LATENCY(10), .DEPTH_LOG2(9)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (en0),
    .write_i  (write_i),
    .ack_o    (ack0),
    .data_o   (dout0)
  );

  dmem_line_responder #(.LATENCY(1), .DEPTH_LOG2(9)) dut1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (en1),
    .write_i  (write_i),
    .ack_o    (ack1),
    .data_o   (dout1)
  );

  typedef struct {
    string        name;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp_data;
    int           exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the ack cycle
  // (or, with hold set, on the ack cycle itself with enable still high).
  task automatic applyStimulus(input bit sel, input logic wr, input logic [31:0] addr,
                               input logic [255:0] data, input bit hold,
                               output int lat, output logic [255:0] rd);
    lat     = -1;
    rd      = '0;
    write_i = wr;
    addr_i  = addr;
    data_i  = data;
    if (sel) en1 = 1'b1;
    else     en0 = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk_i);
      if ((sel ? ack1 : ack0) === 1'b1) begin
        lat = c;
        rd  = sel ? dout1 : dout0;
        break;
      end
    end
    if (!hold) begin
      en0 = 1'b0;
      en1 = 1'b0;
      if (lat > 0) begin
        @(negedge clk_i);
        checkOutput("ack_single_pulse", 256'(sel ? ack1 : ack0), 256'd0);
      end
    end
  endtask

  initial begin
    int           lat;
    int           lat2;
    int           ack_count;
    logic [255:0] rd;

    rst_i   = 1'b0;
    en0     = 1'b0;
    en1     = 1'b0;
    write_i = 1'b0;
    addr_i  = '0;
    data_i  = '0;

    dut.mem[0]  = LINE_P0;
    dut.mem[1]  = LINE_P1;
    dut.mem[3]  = LINE_A5;
    dut.mem[4]  = '0;
    dut.mem[32] = '0;
    dut1.mem[0] = LINE_P0;

    vecs[0] = '{"read_line3",      1'b0, 32'h0000_0060, '0,      LINE_A5, 10};
    vecs[1] = '{"write_line4",     1'b1, 32'h0000_0080, LINE_DB, LINE_A5, 10};
    vecs[2] = '{"read_line4_off",  1'b0, 32'h0000_009C, '0,      LINE_DB, 10};
    vecs[3] = '{"write_alias0",    1'b1, 32'h0000_4000, LINE_X,  LINE_DB, 10};
    vecs[4] = '{"read_line0",      1'b0, 32'h0000_0000, '0,      LINE_X,  10};
    vecs[5] = '{"read_high_alias", 1'b0, 32'hFFFF_C060, '0,      LINE_A5, 10};

    repeat (3) @(negedge clk_i);
    checkOutput("reset_ack0",  256'(ack0), 256'd0);
    checkOutput("reset_data0", dout0,      256'd0);
    checkOutput("reset_ack1",  256'(ack1), 256'd0);
    checkOutput("reset_data1", dout1,      256'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, lat, rd);
      checkOutput({vecs[i].name, "_latency"}, 256'(lat), 256'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_data"}, rd, vecs[i].exp_data);
    end

    // Writeback to line 32, then refill of line 0 accepted right after the ack.
    applyStimulus(1'b0, 1'b1, 32'h0000_0400, LINE_W, 1'b1, lat, rd);
    checkOutput("b2b_write_latency", 256'(lat), 256'd10);
    write_i = 1'b0;
    addr_i  = 32'h0000_0000;
    lat2    = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk_i);
      if (ack0 === 1'b1) begin
        lat2 = c;
        break;
      end
    end
    en0 = 1'b0;
    checkOutput("b2b_ack_spacing", 256'(lat2), 256'd11);
    checkOutput("b2b_read_data",   dout0,      LINE_X);
    checkOutput("b2b_line32",      dut.mem[32], LINE_W);
    @(negedge clk_i);
    checkOutput("b2b_ack_pulse",   256'(ack0), 256'd0);

    // Abort: write to line 1 withdrawn after 4 cycles.
    write_i = 1'b1;
    addr_i  = 32'h0000_0020;
    data_i  = LINE_J;
    en0     = 1'b1;
    repeat (4) @(negedge clk_i);
    en0       = 1'b0;
    ack_count = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (ack0 === 1'b1) ack_count++;
    end
    checkOutput("abort_no_ack", 256'(ack_count), 256'd0);
    checkOutput("abort_line1",  dut.mem[1],      LINE_P1);
    applyStimulus(1'b0, 1'b0, 32'h0000_0020, '0, 1'b0, lat, rd);
    checkOutput("abort_read_latency", 256'(lat), 256'd10);
    checkOutput("abort_read_data",    rd,        LINE_P1);

    // Asynchronous reset in the middle of a write to line 3.
    write_i = 1'b1;
    addr_i  = 32'h0000_0060;
    data_i  = LINE_Z;
    en0     = 1'b1;
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("midreset_ack",  256'(ack0), 256'd0);
    checkOutput("midreset_data", dout0,      256'd0);
    en0 = 1'b0;
    @(negedge clk_i);
    checkOutput("midreset_line3", dut.mem[3], LINE_A5);
    rst_i = 1'b1;
    @(negedge clk_i);
    applyStimulus(1'b0, 1'b0, 32'h0000_0060, '0, 1'b0, lat, rd);
    checkOutput("postreset_latency", 256'(lat), 256'd10);
    checkOutput("postreset_data",    rd,        LINE_A5);

    // LATENCY=1 instance: aliasing write then read, ack on the very next cycle.
    applyStimulus(1'b1, 1'b1, 32'h0000_4000, LINE_V, 1'b0, lat, rd);
    checkOutput("lat1_write_latency", 256'(lat), 256'd1);
    checkOutput("lat1_write_keeps_data", dout1, 256'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0, lat, rd);
    checkOutput("lat1_read_latency", 256'(lat), 256'd1);
    checkOutput("lat1_read_data",    rd,        LINE_V);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
